// File: rtl/spike_sched_pkg.sv
// Shared types and width helpers for the spike scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spike_sched_pkg;

    localparam int DEF_NUM_SYNAPSE_ROWS = 2;
    localparam int DEF_TIME_WIDTH       = 16;
    localparam int DEF_ADDR_WIDTH       = 6;
    localparam int DEF_FIFO_DEPTH       = 8;

    // A single row still needs a 1-bit index port.
    function automatic int row_width(input int num_rows);
        return (num_rows > 1) ? $clog2(num_rows) : 1;
    endfunction

    localparam int DEF_ROW_W = row_width(DEF_NUM_SYNAPSE_ROWS);

    typedef struct packed {
        logic [DEF_TIME_WIDTH-1:0] ts;
        logic [DEF_ROW_W-1:0]      row;
        logic [DEF_ADDR_WIDTH-1:0] addr;
    } spike_event_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

endpackage

// File: rtl/spike_event_fifo.sv
// In-order event buffer with registered full/empty flags and occupancy count.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: in_rdy = !full from a register; a same-cycle pop does not open it.
// Ports: in_vld/in_rdy/in_dat push side, out_vld/out_rdy/out_dat head and pop, count occupancy.
module spike_event_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full_q;
    logic             empty_q;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count_d;

    assign push    = in_vld && !full_q;
    assign pop     = out_rdy && !empty_q;
    assign in_rdy  = !full_q;
    assign out_vld = !empty_q;
    assign out_dat = mem[rd_ptr];

    always_comb begin
        count_d = count;
        if (push && !pop) begin
            count_d = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            // DEPTH is a power of two, so pointers wrap on overflow.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count   <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_dat;
    end

endmodule

// File: rtl/spike_scheduler.sv
// Timestamped spike scheduler: buffers events, runs a time base, pulses each row when due.
// Latency: event with time T (queued in time) pulses in the cycle where timer == T+1.
// Backpressure: evt_ready low while the FIFO is full; at most one dispatch per cycle.
// Ports: start/stop control, evt_* push, spike_valid/spike_addr pulse out, timer/running/fifo_count/late_count status.
// Option SPIKE_SCHED_LATE_DROP_EN: late events are discarded (still counted) instead of dispatched.
module spike_scheduler
    import spike_sched_pkg::*;
#(
    parameter  int NUM_SYNAPSE_ROWS = DEF_NUM_SYNAPSE_ROWS,
    parameter  int TIME_WIDTH       = DEF_TIME_WIDTH,
    parameter  int ADDR_WIDTH       = DEF_ADDR_WIDTH,
    parameter  int FIFO_DEPTH       = DEF_FIFO_DEPTH,
    localparam int ROW_W            = row_width(NUM_SYNAPSE_ROWS),
    localparam int CNT_W            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        evt_valid,
    output logic                        evt_ready,
    input  logic [TIME_WIDTH-1:0]       evt_time,
    input  logic [ROW_W-1:0]            evt_row,
    input  logic [ADDR_WIDTH-1:0]       evt_addr,
    output logic [NUM_SYNAPSE_ROWS-1:0] spike_valid,
    output logic [ADDR_WIDTH-1:0]       spike_addr,
    output logic [TIME_WIDTH-1:0]       timer,
    output logic                        running,
    output logic [CNT_W-1:0]            fifo_count,
    output logic [7:0]                  late_count
);

    typedef struct packed {
        logic [TIME_WIDTH-1:0] ts;
        logic [ROW_W-1:0]      row;
        logic [ADDR_WIDTH-1:0] addr;
    } evt_t;

    localparam logic [ROW_W:0] NUM_ROWS_L = NUM_SYNAPSE_ROWS[ROW_W:0];

    sched_state_t          state_q;
    sched_state_t          state_d;
    logic [TIME_WIDTH-1:0] timer_q;
    logic [TIME_WIDTH-1:0] timer_d;
    evt_t                  in_evt;
    evt_t                  head;
    logic                  head_vld;
    logic [TIME_WIDTH-1:0] delta;
    logic                  is_late;
    logic                  pop;
    logic                  fire;

    assign in_evt  = '{ts: evt_time, row: evt_row, addr: evt_addr};
    assign timer   = timer_q;
    assign running = (state_q == RUN);

    spike_event_fifo #(
        .WIDTH ($bits(evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (evt_valid),
        .in_rdy  (evt_ready),
        .in_dat  (in_evt),
        .out_vld (head_vld),
        .out_rdy (pop),
        .out_dat (head),
        .count   (fifo_count)
    );

    // Next state and time base; stop has priority over start.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                    timer_d = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIME_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Due test: head.ts - timer as a signed wrap-aware distance; <= 0 means due.
    always_comb begin
        delta   = head.ts - timer_q;
        is_late = delta[TIME_WIDTH-1];
        pop     = (state_q == RUN) && head_vld && (is_late || (delta == '0));
        fire    = pop && ({1'b0, head.row} < NUM_ROWS_L);
`ifdef SPIKE_SCHED_LATE_DROP_EN
        if (is_late) fire = 1'b0;
`else
        fire    = fire && 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            spike_valid <= '0;
            spike_addr  <= '0;
            late_count  <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            spike_valid <= fire ? (NUM_SYNAPSE_ROWS'(1) << head.row) : '0;
            if (fire) spike_addr <= head.addr;
            if (pop && is_late && (late_count != 8'hFF)) begin
                late_count <= late_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_spike_scheduler.sv
// Self-checking bench for spike_scheduler: queue-based reference model plus literal pins.
// Latency: n/a.
// Backpressure: n/a.
module tb_spike_scheduler;

`ifdef SPIKE_SCHED_LATE_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic        evt_valid;
    logic        evt_ready;
    logic [15:0] evt_time;
    logic [0:0]  evt_row;
    logic [5:0]  evt_addr;
    logic [1:0]  spike_valid;
    logic [5:0]  spike_addr;
    logic [15:0] timer;
    logic        running;
    logic [3:0]  fifo_count;
    logic [7:0]  late_count;

    logic        w_start;
    logic        w_evt_valid;
    logic        w_evt_ready;
    logic [3:0]  w_evt_time;
    logic [0:0]  w_evt_row;
    logic [5:0]  w_evt_addr;
    logic [1:0]  w_spike_valid;
    logic [5:0]  w_spike_addr;
    logic [3:0]  w_timer;
    logic        w_running;
    logic [3:0]  w_fifo_count;
    logic [7:0]  w_late_count;

    spike_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_time(evt_time),
        .evt_row(evt_row), .evt_addr(evt_addr), .spike_valid(spike_valid),
        .spike_addr(spike_addr), .timer(timer), .running(running),
        .fifo_count(fifo_count), .late_count(late_count)
    );

    spike_scheduler #(.TIME_WIDTH(4)) dut_wrap (
        .clk(clk), .reset(reset), .start(w_start), .stop(1'b0),
        .evt_valid(w_evt_valid), .evt_ready(w_evt_ready), .evt_time(w_evt_time),
        .evt_row(w_evt_row), .evt_addr(w_evt_addr), .spike_valid(w_spike_valid),
        .spike_addr(w_spike_addr), .timer(w_timer), .running(w_running),
        .fifo_count(w_fifo_count), .late_count(w_late_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchecks = 0;
    int nerr    = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: spec rules over a queue of pending events.
    typedef struct {
        logic [15:0] t;
        logic [0:0]  r;
        logic [5:0]  a;
    } ev_t;

    ev_t         mq[$];
    logic [15:0] m_timer = '0;
    bit          m_run   = 1'b0;
    logic [1:0]  m_sv    = '0;
    logic [5:0]  m_sa    = '0;
    int          m_late  = 0;

    always @(posedge clk) begin : model
        ev_t         h;
        bit          acc;
        logic [15:0] d;
        if (!reset) begin
            mq.delete();
            m_timer = '0;
            m_run   = 1'b0;
            m_sv    = '0;
            m_sa    = '0;
            m_late  = 0;
        end else begin
            acc  = evt_valid && (mq.size() < 8);
            m_sv = 2'b00;
            if (m_run && mq.size() > 0) begin
                d = mq[0].t - m_timer;
                if ($signed(d) <= 0) begin
                    h = mq.pop_front();
                    if ($signed(d) < 0 && m_late < 255) m_late++;
                    if (!(DROP && $signed(d) < 0)) begin
                        m_sv = 2'b01 << h.r;
                        m_sa = h.a;
                    end
                end
            end
            if (acc) mq.push_back('{evt_time, evt_row, evt_addr});
            if (m_run) begin
                if (stop)       m_run = 1'b0;
                else if (start) m_timer = '0;
                else            m_timer = m_timer + 16'd1;
            end else if (start && !stop) begin
                m_run   = 1'b1;
                m_timer = '0;
            end
        end
    end

    always @(negedge clk) begin : compare
        if (chk_en) begin
            chk("cyc_timer",      timer,       m_timer);
            chk("cyc_running",    running,     m_run);
            chk("cyc_fifo_count", fifo_count,  mq.size());
            chk("cyc_evt_ready",  evt_ready,   mq.size() < 8);
            chk("cyc_spike_vld",  spike_valid, m_sv);
            chk("cyc_spike_addr", spike_addr,  m_sa);
            chk("cyc_late_count", late_count,  m_late);
        end
    end

    typedef struct {
        logic [15:0] t;
        logic [1:0]  sv;
        logic [5:0]  a;
    } pulse_t;

    pulse_t plog[$];
    pulse_t wlog[$];

    always @(negedge clk) begin : pulse_logger
        if (spike_valid != 2'b00)   plog.push_back('{timer, spike_valid, spike_addr});
        if (w_spike_valid != 2'b00) wlog.push_back('{{12'd0, w_timer}, w_spike_valid, w_spike_addr});
    end

    // Call at a negedge; returns at a negedge after the accepting edge.
    task automatic push(input logic [15:0] t, input logic [0:0] r, input logic [5:0] a,
                        output logic [15:0] tacc);
        bit done;
        done      = 1'b0;
        tacc      = '1;
        evt_valid = 1'b1;
        evt_time  = t;
        evt_row   = r;
        evt_addr  = a;
        for (int i = 0; i < 200 && !done; i++) begin
            done = evt_ready;
            if (done) tacc = timer;
            @(negedge clk);
        end
        evt_valid = 1'b0;
        nchecks++;
        if (!done) begin
            nerr++;
            $display("FAIL push_timeout: event addr %0d not accepted in 200 cycles", a);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic wait_timer(input logic [15:0] tgt, input int budget);
        int n;
        n = 0;
        while (timer !== tgt && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_timer", timer, tgt);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [15:0] tacc;
        reset = 1'b0; start = 1'b0; stop = 1'b0;
        evt_valid = 1'b0; evt_time = '0; evt_row = '0; evt_addr = '0;
        w_start = 1'b0; w_evt_valid = 1'b0; w_evt_time = '0; w_evt_row = '0; w_evt_addr = '0;

        // Reset state after two low edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_timer", timer, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_evt_ready", evt_ready, 1);
        chk("rst_running", running, 0);
        chk("rst_spike_valid", spike_valid, 0);
        chk("rst_spike_addr", spike_addr, 0);
        chk("rst_late_count", late_count, 0);
        reset  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // Idle: events buffer, nothing dispatches.
        push(16'd50,  1'b0, 6'd1, tacc);
        push(16'd100, 1'b1, 6'd2, tacc);
        push(16'd150, 1'b0, 6'd3, tacc);
        repeat (4) @(negedge clk);
        chk("idle_fifo_count", fifo_count, 3);
        chk("idle_timer", timer, 0);
        chk("idle_no_pulses", plog.size(), 0);

        // Basic schedule.
        pulse_start();
        wait_timer(16'd160, 300);
        chk("basic_npulse", plog.size(), 3);
        if (plog.size() == 3) begin
            chk("basic_p0_t", plog[0].t, 51);  chk("basic_p0_v", plog[0].sv, 2'b01); chk("basic_p0_a", plog[0].a, 1);
            chk("basic_p1_t", plog[1].t, 101); chk("basic_p1_v", plog[1].sv, 2'b10); chk("basic_p1_a", plog[1].a, 2);
            chk("basic_p2_t", plog[2].t, 151); chk("basic_p2_v", plog[2].sv, 2'b01); chk("basic_p2_a", plog[2].a, 3);
        end
        chk("basic_late", late_count, 0);

        // Same timestamp.
        pulse_stop();
        plog.delete();
        push(16'd20, 1'b0, 6'd4, tacc);
        push(16'd20, 1'b1, 6'd5, tacc);
        push(16'd20, 1'b0, 6'd6, tacc);
        pulse_start();
        wait_timer(16'd30, 100);
        if (DROP) begin
            chk("same_npulse", plog.size(), 1);
            if (plog.size() == 1) begin
                chk("same_p0_t", plog[0].t, 21); chk("same_p0_a", plog[0].a, 4);
            end
        end else begin
            chk("same_npulse", plog.size(), 3);
            if (plog.size() == 3) begin
                chk("same_p0_t", plog[0].t, 21); chk("same_p0_a", plog[0].a, 4);
                chk("same_p1_t", plog[1].t, 22); chk("same_p1_v", plog[1].sv, 2'b10);
                chk("same_p2_t", plog[2].t, 23); chk("same_p2_a", plog[2].a, 6);
            end
        end
        chk("same_late", late_count, 2);

        // Full FIFO: ninth offer waits for the first pop after start.
        pulse_stop();
        for (int i = 0; i < 8; i++) begin
            push(16'(10 + i), 1'(i % 2), 6'(8 + i), tacc);
        end
        chk("full_evt_ready", evt_ready, 0);
        chk("full_fifo_count", fifo_count, 8);
        plog.delete();
        fork
            push(16'd18, 1'b0, 6'd16, tacc);
            begin
                repeat (3) @(negedge clk);
                pulse_start();
            end
        join
        chk("full_accept_time", tacc, 11);
        wait_timer(16'd25, 100);
        chk("full_npulse", plog.size(), 9);
        if (plog.size() == 9) begin
            chk("full_p0_t", plog[0].t, 11); chk("full_p0_a", plog[0].a, 8);
            chk("full_p1_t", plog[1].t, 12); chk("full_p1_v", plog[1].sv, 2'b10);
            chk("full_p8_t", plog[8].t, 19); chk("full_p8_a", plog[8].a, 16);
        end
        chk("full_late", late_count, 2);

        // Queue a far event for the stop test, then run the wrap test.
        push(16'd100, 1'b1, 6'd20, tacc);
        plog.delete();

        w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        for (int i = 0; i < 40 && w_timer != 4'd14; i++) @(negedge clk);
        chk("wrap_reach14", w_timer, 14);
        w_evt_valid = 1'b1; w_evt_time = 4'd2; w_evt_row = 1'b0; w_evt_addr = 6'd7;
        @(negedge clk);
        w_evt_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("wrap_npulse", wlog.size(), 1);
        if (wlog.size() == 1) begin
            chk("wrap_p0_t", wlog[0].t, 3); chk("wrap_p0_v", wlog[0].sv, 2'b01); chk("wrap_p0_a", wlog[0].a, 7);
        end
        chk("wrap_late", w_late_count, 0);
        chk("wrap_running", w_running, 1);
        chk("wrap_fifo_empty", w_fifo_count, 0);
        chk("wrap_ready", w_evt_ready, 1);

        // Stop mid-run, then reset mid-operation.
        wait_timer(16'd60, 100);
        pulse_stop();
        repeat (5) @(negedge clk);
        chk("stop_timer", timer, 60);
        chk("stop_running", running, 0);
        chk("stop_fifo_count", fifo_count, 1);
        chk("stop_no_pulse", plog.size(), 0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rst2_fifo_count", fifo_count, 0);
        chk("rst2_timer", timer, 0);
        chk("rst2_running", running, 0);
        chk("rst2_late", late_count, 0);
        chk("rst2_wrap_fifo", w_fifo_count, 0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/spike_scheduler.md
Name: spike_scheduler

Overview:
- Timestamped spike-event scheduler in front of the synapse-row inputs of nn.
- Accepts events (time, row, address) from a host/transactor, buffers them in an in-order FIFO, and runs a free-running time base.
- Dispatches each event as a one-cycle spike pulse on its target synapse row when its timestamp is due.
- Replaces the bench-side spike timing loop with synthesizable sequencing.

Parameters:
- NUM_SYNAPSE_ROWS, 2, number of synapse rows driven; one spike output per row.
- TIME_WIDTH, 16, width of the timestamp and internal timer.
- ADDR_WIDTH, 6, width of the spike address broadcast with each spike.
- FIFO_DEPTH, 8, event buffer depth; power of two, ≥2.

Ports:
- clk  in  1  system clock, the fast clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse: IDLE→RUN, timer cleared to 0.
- stop  in  1  one-cycle pulse: RUN→IDLE; FIFO contents kept.
- evt_valid  in  1  event offered.
- evt_ready  out  1  FIFO not full.
- evt_time  in  TIME_WIDTH  absolute dispatch time.
- evt_row  in  $clog2(NUM_SYNAPSE_ROWS)  target row.
- evt_addr  in  ADDR_WIDTH  spike address.
- spike_valid  out  NUM_SYNAPSE_ROWS  one-hot pulse on the target row.
- spike_addr  out  ADDR_WIDTH  address accompanying spike_valid.
- timer  out  TIME_WIDTH  current time base.
- running  out  1  high in RUN.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.
- late_count  out  8  saturating count of late events.

Behaviour:
- Reset (reset==0 at a clk edge) drives these values:
  - state IDLE, timer 0, FIFO empty (fifo_count 0, evt_ready 1).
  - spike_valid 0, spike_addr 0, running 0, late_count 0.
- Event acceptance: an event is accepted when evt_valid && evt_ready. It is written at the tail and visible to dispatch logic the next cycle.
  - Events accepted in any state.
  - Events must arrive in non-decreasing time order; out-of-order events are dispatched in FIFO order regardless.
- FSM, IDLE:
  - Timer held.
  - No dispatch.
  - start → RUN with timer=0 on the next cycle.
- FSM, RUN:
  - timer increments by 1 every cycle and wraps modulo 2^TIME_WIDTH.
  - stop → IDLE, timer held at its current value.
  - start while in RUN restarts the timer at 0.
  - start and stop in the same cycle: stop wins.
- Due test (RUN only):
  - d = head.time − timer, as a TIME_WIDTH-bit two's-complement value.
  - Due when d ≤ 0. Late when d < 0.
  - This handles timer wrap for events within 2^(TIME_WIDTH−1) of the timer.
- Dispatch:
  - At most one event per cycle.
  - Due head is popped, and on the next cycle spike_valid[head.row]=1 and spike_addr=head.addr for exactly one cycle.
  - Latency: an event with time T, accepted before the timer reaches T, pulses in the cycle where timer==T+1.
  - Events sharing the same T pulse on consecutive cycles; every one after the first counts as late.
- Late events: late_count increments and saturates at 255.
- Simultaneous push and pop: both take effect; fifo_count unchanged.
  - When full, evt_ready is 0 in that cycle even if a pop occurs (no combinational ready-through).
- Row index ≥ NUM_SYNAPSE_ROWS: event popped, no pulse, spike_addr unchanged.
- Reset mid-operation: everything returns to reset values, including in-flight pulses and buffered events.
- spike_addr holds its last value when spike_valid is 0.

Optional Feature:
- Macro: SPIKE_SCHED_LATE_DROP_EN.
- Defined: late events (d<0) are popped without a pulse and still increment late_count. On-time (d==0) events dispatch normally.
- Undefined: late events are dispatched as soon as they reach the head.

Decomposition:
- Package spike_sched_pkg:
  - typedef spike_event_t {time, row, addr}.
  - enum sched_state_t {IDLE, RUN}.
  - Width helper constants derived from the parameters.
- Sub-module spike_event_fifo: synchronous FIFO with registered full/empty and count; parameterized on the element type width.
- spike_scheduler holds the timer, FSM, due compare and output register.

Test Plan:
- Reset/idle: hold reset low for 2 cycles, push 3 events, no start → spike_valid stays 0, fifo_count=3, timer=0.
- Basic schedule: events (50,row0,1), (100,row1,2), (150,row0,3), then start.
  - spike_valid=2'b01 with addr 1 at timer 51.
  - spike_valid=2'b10 with addr 2 at timer 101.
  - spike_valid=2'b01 with addr 3 at timer 151.
  - late_count=0.
- Same timestamp: three events at T=20 on rows 0,1,0 → pulses at timers 21,22,23, late_count=2. With SPIKE_SCHED_LATE_DROP_EN: one pulse at 21, late_count=2.
- Full FIFO: push FIFO_DEPTH events while IDLE → evt_ready=0, fifo_count=8. A 9th offer is held until the first pop after start, then accepted.
- Wrap: TIME_WIDTH=4; start, then push event T=2 when timer=14 → pulse at timer=3 after wrap, late_count=0.
- Stop/reset mid-run: stop at timer 60 with event at 100 queued → no pulse, timer frozen at 60. Then drive reset low at an edge → fifo_count=0, timer=0, running=0.
